// File: rtl/matrix_gen_multi.sv
// rtl/matrix_gen_multi.sv - multi-mode matrix fill generator writing one storage slot row-major
// Optional feature: define MATGEN_SEED_LOAD_EN to add seed_load/seed ports for reseeding the LFSR in IDLE.
module matrix_gen_multi #(
    parameter int          DATA_W    = 16,
    parameter int          DIM_W     = 3,
    parameter int          SLOT_W    = 2,
    parameter int          MAX_DIM   = 5,
    parameter int          VAL_BITS  = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [DIM_W-1:0]  target_m,
    input  logic [DIM_W-1:0]  target_n,
    input  logic [SLOT_W-1:0] target_slot,
    input  logic [DATA_W-1:0] fill_value,
    input  logic [VAL_BITS-1:0] max_val,
    input  logic              wr_ready,
`ifdef MATGEN_SEED_LOAD_EN
    input  logic              seed_load,
    input  logic [15:0]       seed,
`endif
    output logic [SLOT_W-1:0] gen_slot_idx,
    output logic [DIM_W-1:0]  gen_row,
    output logic [DIM_W-1:0]  gen_col,
    output logic [DATA_W-1:0] gen_data,
    output logic              gen_we,
    output logic [DIM_W-1:0]  gen_dim_m,
    output logic [DIM_W-1:0]  gen_dim_n,
    output logic              gen_dim_we,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {S_IDLE, S_DIM, S_GEN, S_DONE} state_t;

    localparam logic [1:0] MODE_RAND  = 2'd0;
    localparam logic [1:0] MODE_ZERO  = 2'd1;
    localparam logic [1:0] MODE_IDENT = 2'd2;
    localparam logic [1:0] MODE_CONST = 2'd3;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    state_t              state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    logic [DATA_W-1:0]   fill_q, fill_d;
    logic [VAL_BITS-1:0] max_q, max_d;
    logic [DIM_W-1:0]    cnt_i_q, cnt_i_d, cnt_j_q, cnt_j_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [SLOT_W-1:0]   slot_d;
    logic [DIM_W-1:0]    row_d, col_d, dim_m_d, dim_n_d;
    logic [DATA_W-1:0]   data_d;
    logic                we_d, dim_we_d, busy_d, done_d, err_d;

    // Scratch values for loading the next element into the output register
    logic [15:0]         cur;
    logic [DATA_W-1:0]   elem;
    logic [DIM_W-1:0]    ld_i, ld_j;
    logic                accept, last, do_load, bad_dim;

    // Next-state, element selection, rejection sampling and output staging
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        fill_d   = fill_q;
        max_d    = max_q;
        cnt_i_d  = cnt_i_q;
        cnt_j_d  = cnt_j_q;
        lfsr_d   = lfsr_q;
        slot_d   = gen_slot_idx;
        row_d    = gen_row;
        col_d    = gen_col;
        data_d   = gen_data;
        we_d     = gen_we;
        dim_m_d  = gen_dim_m;
        dim_n_d  = gen_dim_n;
        dim_we_d = gen_dim_we;
        done_d   = 1'b0;
        err_d    = 1'b0;
        do_load  = 1'b0;

        accept  = gen_we && wr_ready;
        last    = (gen_row == gen_dim_m - 1'b1) && (gen_col == gen_dim_n - 1'b1);
        // The presented random value always equals the LFSR's low bits, so an
        // acceptance steps the LFSR before the next candidate is drawn.
        cur     = accept ? lfsr_step(lfsr_q) : lfsr_q;
        ld_i    = (state_q == S_DIM) ? '0 : cnt_i_q;
        ld_j    = (state_q == S_DIM) ? '0 : cnt_j_q;
        bad_dim = (target_m == '0) || (target_n == '0) ||
                  (target_m > DIM_W'(MAX_DIM)) || (target_n > DIM_W'(MAX_DIM));

        case (mode_q)
            MODE_ZERO:  elem = '0;
            MODE_IDENT: elem = (ld_i == ld_j) ? DATA_W'(1) : '0;
            MODE_CONST: elem = fill_q;
            default:    elem = DATA_W'(cur[VAL_BITS-1:0]);
        endcase

        case (state_q)
            S_IDLE: begin
`ifdef MATGEN_SEED_LOAD_EN
                if (seed_load)
                    lfsr_d = (seed == 16'h0) ? LFSR_SEED : seed;
`endif
                if (start) begin
                    if (bad_dim) begin
                        err_d = 1'b1;
                    end else begin
                        mode_d   = mode;
                        fill_d   = fill_value;
                        max_d    = max_val;
                        slot_d   = target_slot;
                        dim_m_d  = target_m;
                        dim_n_d  = target_n;
                        dim_we_d = 1'b1;
                        state_d  = S_DIM;
                    end
                end
            end
            S_DIM: begin
                if (wr_ready) begin
                    dim_we_d = 1'b0;
                    state_d  = S_GEN;
                    do_load  = 1'b1;
                end
            end
            S_GEN: begin
                if (accept && last) begin
                    we_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                    if (mode_q == MODE_RAND)
                        lfsr_d = cur;
                end else if (!gen_we || wr_ready) begin
                    do_load = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (do_load) begin
            if (mode_q == MODE_RAND && cur[VAL_BITS-1:0] > max_q) begin
                we_d   = 1'b0;
                lfsr_d = lfsr_step(cur);
            end else begin
                we_d   = 1'b1;
                row_d  = ld_i;
                col_d  = ld_j;
                data_d = elem;
                if (mode_q == MODE_RAND)
                    lfsr_d = cur;
                if (ld_j == gen_dim_n - 1'b1) begin
                    cnt_j_d = '0;
                    cnt_i_d = ld_i + 1'b1;
                end else begin
                    cnt_j_d = ld_j + 1'b1;
                    cnt_i_d = ld_i;
                end
            end
        end

        if (abort && state_q != S_IDLE) begin
            state_d  = S_IDLE;
            we_d     = 1'b0;
            dim_we_d = 1'b0;
            done_d   = 1'b0;
        end

        busy_d = (state_d == S_DIM) || (state_d == S_GEN);
    end

    // State, job context, LFSR and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            mode_q       <= '0;
            fill_q       <= '0;
            max_q        <= '0;
            cnt_i_q      <= '0;
            cnt_j_q      <= '0;
            lfsr_q       <= LFSR_SEED;
            gen_slot_idx <= '0;
            gen_row      <= '0;
            gen_col      <= '0;
            gen_data     <= '0;
            gen_we       <= 1'b0;
            gen_dim_m    <= '0;
            gen_dim_n    <= '0;
            gen_dim_we   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            fill_q       <= fill_d;
            max_q        <= max_d;
            cnt_i_q      <= cnt_i_d;
            cnt_j_q      <= cnt_j_d;
            lfsr_q       <= lfsr_d;
            gen_slot_idx <= slot_d;
            gen_row      <= row_d;
            gen_col      <= col_d;
            gen_data     <= data_d;
            gen_we       <= we_d;
            gen_dim_m    <= dim_m_d;
            gen_dim_n    <= dim_n_d;
            gen_dim_we   <= dim_we_d;
            busy         <= busy_d;
            done         <= done_d;
            err          <= err_d;
        end
    end

endmodule

// File: tb/tb_matrix_gen_multi.sv
// tb/tb_matrix_gen_multi.sv - directed self-checking bench for matrix_gen_multi
module tb_matrix_gen_multi;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [2:0]  target_m = 3'd0;
    logic [2:0]  target_n = 3'd0;
    logic [1:0]  target_slot = 2'd0;
    logic [15:0] fill_value = 16'd0;
    logic [3:0]  max_val = 4'd0;
    logic        wr_ready = 1'b1;
    logic [1:0]  gen_slot_idx;
    logic [2:0]  gen_row, gen_col, gen_dim_m, gen_dim_n;
    logic [15:0] gen_data;
    logic        gen_we, gen_dim_we, busy, done, err;

    int checks = 0;
    int errors = 0;

    int n_acc, dim_cyc, done_cyc, err_cyc, abort_cyc;
    int we_seen, dim_seen, busy_seen, stall_bad;
    int acc_row[32], acc_col[32], acc_data[32], acc_cyc[32];
    int dim_m_r, dim_n_r, slot_r;
    logic busy_at_done, we_after_abort, busy_after_abort;

    matrix_gen_multi dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
        .target_m(target_m), .target_n(target_n), .target_slot(target_slot),
        .fill_value(fill_value), .max_val(max_val), .wr_ready(wr_ready),
        .gen_slot_idx(gen_slot_idx), .gen_row(gen_row), .gen_col(gen_col),
        .gen_data(gen_data), .gen_we(gen_we), .gen_dim_m(gen_dim_m),
        .gen_dim_n(gen_dim_n), .gen_dim_we(gen_dim_we), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Issue one job; cycle 0 is the start cycle, sampling happens 1 time unit after each edge
    task automatic run_job(input logic [1:0] md, input int m, input int n, input int slot,
                           input int fv, input int mv, input bit toggle, input int abort_after);
        int c;
        bit fin, p_we, p_rdy;
        int p_row, p_col, p_data;
        n_acc = 0; dim_cyc = -1; done_cyc = -1; err_cyc = -1; abort_cyc = -1;
        we_seen = 0; dim_seen = 0; busy_seen = 0; stall_bad = 0;
        dim_m_r = -1; dim_n_r = -1; slot_r = -1;
        busy_at_done = 1'bx; we_after_abort = 1'bx; busy_after_abort = 1'bx;
        for (int k = 0; k < 32; k++) begin
            acc_row[k] = -1; acc_col[k] = -1; acc_data[k] = -1; acc_cyc[k] = -1;
        end
        p_we = 0; p_rdy = 1; p_row = 0; p_col = 0; p_data = 0;
        mode = md; target_m = 3'(m); target_n = 3'(n); target_slot = 2'(slot);
        fill_value = 16'(fv); max_val = 4'(mv);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        c = 1;
        fin = 0;
        while (!fin) begin
            wr_ready = toggle ? (c % 2 == 1) : 1'b1;
            if (p_we && !p_rdy &&
                (!gen_we || int'(gen_row) != p_row || int'(gen_col) != p_col || int'(gen_data) != p_data))
                stall_bad++;
            if (gen_dim_we) dim_seen++;
            if (gen_we) we_seen++;
            if (busy) busy_seen++;
            if (gen_dim_we && wr_ready && dim_cyc < 0) begin
                dim_cyc = c; dim_m_r = int'(gen_dim_m); dim_n_r = int'(gen_dim_n); slot_r = int'(gen_slot_idx);
            end
            if (gen_we && wr_ready && n_acc < 32) begin
                acc_row[n_acc] = int'(gen_row); acc_col[n_acc] = int'(gen_col);
                acc_data[n_acc] = int'(gen_data); acc_cyc[n_acc] = c;
                n_acc++;
                if (n_acc == abort_after) begin
                    abort = 1'b1;
                    abort_cyc = c;
                end
            end
            if (done && done_cyc < 0) begin
                done_cyc = c;
                busy_at_done = busy;
            end
            if (err && err_cyc < 0) err_cyc = c;
            p_we = gen_we; p_rdy = wr_ready;
            p_row = int'(gen_row); p_col = int'(gen_col); p_data = int'(gen_data);
            @(posedge clk);
            #1 abort = 1'b0;
            c++;
            if (abort_cyc >= 0 && c == abort_cyc + 1) begin
                we_after_abort = gen_we;
                busy_after_abort = busy;
            end
            if (done_cyc >= 0 || c > 60 || (abort_cyc >= 0 && c > abort_cyc + 6) ||
                (err_cyc >= 0 && c > 4))
                fin = 1;
        end
        wr_ready = 1'b1;
    endtask

    initial begin
        int exp_v[4];
        int exp_c[4];

        // Reset state
        #3;
        chk("reset_outputs", {gen_slot_idx, gen_row, gen_col, gen_data, gen_we,
                              gen_dim_m, gen_dim_n, gen_dim_we, busy, done, err}, 0);
        do_reset();
        chk("post_reset_busy", busy, 0);

        // Zero mode 2x3, minimum latency
        run_job(2'd1, 2, 3, 2, 0, 0, 0, -1);
        chk("zero_dim_cyc", dim_cyc, 1);
        chk("zero_dim_m", dim_m_r, 2);
        chk("zero_dim_n", dim_n_r, 3);
        chk("zero_slot", slot_r, 2);
        chk("zero_count", n_acc, 6);
        for (int k = 0; k < 6; k++) begin
            chk("zero_row", acc_row[k], k / 3);
            chk("zero_col", acc_col[k], k % 3);
            chk("zero_data", acc_data[k], 0);
            chk("zero_cyc", acc_cyc[k], k + 2);
        end
        chk("zero_done_cyc", done_cyc, 8);
        chk("zero_busy_at_done", busy_at_done, 0);

        // Identity 3x3
        run_job(2'd2, 3, 3, 1, 0, 0, 0, -1);
        chk("ident_count", n_acc, 9);
        for (int k = 0; k < 9; k++) begin
            chk("ident_pos", acc_row[k] * 8 + acc_col[k], (k / 3) * 8 + (k % 3));
            chk("ident_data", acc_data[k], ((k / 3) == (k % 3)) ? 1 : 0);
        end
        chk("ident_done_cyc", done_cyc, 11);

        // Constant 1x4
        run_job(2'd3, 1, 4, 3, 16'h00AB, 0, 0, -1);
        chk("const_count", n_acc, 4);
        for (int k = 0; k < 4; k++) chk("const_data", acc_data[k], 16'h00AB);
        chk("const_done_cyc", done_cyc, 6);

        // Random, unfiltered, from reset seed: low nibbles of ACE1, 59C3, B387, 670F
        do_reset();
        run_job(2'd0, 2, 2, 0, 0, 4'hF, 0, -1);
        exp_v = '{1, 3, 7, 15};
        chk("rand_f_count", n_acc, 4);
        for (int k = 0; k < 4; k++) chk("rand_f_data", acc_data[k], exp_v[k]);
        chk("rand_f_done_cyc", done_cyc, 6);

        // Random, max 3: raws 1,3,7,F,E,C,9,2,4,8,1 -> writes 1,3,2,1 with gaps
        do_reset();
        run_job(2'd0, 2, 2, 0, 0, 4'h3, 0, -1);
        exp_v = '{1, 3, 2, 1};
        exp_c = '{2, 3, 9, 12};
        chk("rand_3_count", n_acc, 4);
        for (int k = 0; k < 4; k++) begin
            chk("rand_3_data", acc_data[k], exp_v[k]);
            chk("rand_3_cyc", acc_cyc[k], exp_c[k]);
            chk("rand_3_pos", acc_row[k] * 8 + acc_col[k], (k / 2) * 8 + (k % 2));
        end
        chk("rand_3_gen_we_cycles", we_seen, 4);
        chk("rand_3_done_cyc", done_cyc, 13);

        // Random with wr_ready toggling
        do_reset();
        run_job(2'd0, 2, 2, 0, 0, 4'hF, 1, -1);
        exp_v = '{1, 3, 7, 15};
        chk("stall_count", n_acc, 4);
        chk("stall_stable", stall_bad, 0);
        for (int k = 0; k < 4; k++) begin
            chk("stall_data", acc_data[k], exp_v[k]);
            chk("stall_pos", acc_row[k] * 8 + acc_col[k], (k / 2) * 8 + (k % 2));
        end
        chk("stall_done_seen", done_cyc > 0, 1);

        // Illegal dimensions
        run_job(2'd1, 0, 3, 0, 0, 0, 0, -1);
        chk("err_m0_cyc", err_cyc, 1);
        chk("err_m0_dim_we", dim_seen, 0);
        chk("err_m0_we", we_seen, 0);
        chk("err_m0_busy", busy_seen, 0);
        run_job(2'd1, 2, 6, 0, 0, 0, 0, -1);
        chk("err_n6_cyc", err_cyc, 1);
        chk("err_n6_dim_we", dim_seen, 0);
        chk("err_n6_we", we_seen, 0);
        chk("err_n6_busy", busy_seen, 0);

        // Abort after third accepted write of 3x3
        run_job(2'd1, 3, 3, 1, 0, 0, 0, 3);
        chk("abort_count", n_acc, 3);
        chk("abort_we_next", we_after_abort, 0);
        chk("abort_busy_next", busy_after_abort, 0);
        chk("abort_no_done", done_cyc, 32'hFFFF_FFFF);
        chk("abort_we_cycles", we_seen, 3);

        // Normal 1x1 after abort
        run_job(2'd3, 1, 1, 2, 16'h1234, 0, 0, -1);
        chk("one_count", n_acc, 1);
        chk("one_data", acc_data[0], 16'h1234);
        chk("one_done_cyc", done_cyc, 3);

        // Asynchronous reset mid-job
        mode = 2'd1; target_m = 3'd3; target_n = 3'd3; target_slot = 2'd3;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        chk("midjob_busy_before", {busy, gen_we}, 2'b11);
        rst_n = 1'b0;
        #1;
        chk("midjob_reset_outputs", {gen_slot_idx, gen_row, gen_col, gen_data, gen_we,
                                     gen_dim_m, gen_dim_n, gen_dim_we, busy, done, err}, 0);
        #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("midjob_idle_after", {busy, gen_we, gen_dim_we}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
